vme_master_cycle_ctrl: RTL and testbench

//  Per-master VME transfer sequencer between local command port and shared VME bus.

---
 rtl/vme_pkg.sv | 6 +
 rtl/vme_sync2.sv | 12 +
 rtl/vme_master_cycle_ctrl.sv | 115 +++++++++++
 tb/tb_vme_master_cycle_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vme_pkg.sv
// vme_pkg: response codes, sequencer states and bus release modes for the VME master
package vme_pkg;
   typedef enum logic [2:0] {IDLE, REQ, SETUP, DSTB, TERM, PARK} state_t;
   localparam logic [1:0] RSP_OK = 2'b00, RSP_BERR = 2'b01, RSP_TMO = 2'b10;
   localparam int RWD = 0, ROR = 1;
endpackage

// File: rtl/vme_sync2.sv
// vme_sync2: two-flop synchronizer for asynchronous VME/arbiter inputs
module vme_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic m;
   always_ff @(posedge clk or posedge rst)
      if (rst) {q, m} <= 2'b00;
      else {q, m} <= {m, d};
endmodule

// File: rtl/vme_master_cycle_ctrl.sv
// vme_master_cycle_ctrl: arbitrates for the VME bus and runs one single-word cycle per command
module vme_master_cycle_ctrl
   import vme_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int SETUP_CYC    = 2,
   parameter int TIMEOUT_CYC  = 64,
   parameter int RELEASE_MODE = 0
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   output logic [1:0]    rsp_err,
   output logic [DW-1:0] rsp_rdata,
   output logic          bus_req,
   input  logic          bus_grant,
   input  logic          other_req,
   output logic          vme_bbsy,
   output logic          vme_as,
   output logic          vme_ds,
   output logic          vme_write,
   output logic [AW-1:0] vme_addr,
   output logic [DW-1:0] vme_dout,
   output logic          vme_doe,
   input  logic [DW-1:0] vme_din,
   input  logic          vme_dtack,
   input  logic          vme_berr
);
   localparam int SW = $clog2(SETUP_CYC + 1);
   localparam int CW = $clog2(TIMEOUT_CYC);
   localparam logic [SW-1:0] S_LAST = SW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYC - 1);

   logic grant_s, dtack_s, berr_s;
   vme_sync2 u_grant (.clk(clk), .rst(rst), .d(bus_grant), .q(grant_s));
   vme_sync2 u_dtack (.clk(clk), .rst(rst), .d(vme_dtack), .q(dtack_s));
   vme_sync2 u_berr  (.clk(clk), .rst(rst), .d(vme_berr),  .q(berr_s));

   state_t        state, nxt;
   logic [SW-1:0] scnt;
   logic [CW-1:0] tcnt;
   logic          wr_l, tmo_l, sticky, accept, done;
   logic [AW-1:0] addr_l;
   logic [DW-1:0] wdata_l;
   logic [1:0]    err_n;

   assign bus_req   = state == REQ;
   assign vme_bbsy  = state == SETUP || state == DSTB || state == TERM || state == PARK;
   assign vme_as    = state == DSTB;
   assign vme_ds    = state == DSTB;
   assign vme_doe   = wr_l && (state == SETUP || state == DSTB);
   assign vme_write = vme_bbsy && wr_l;
   assign vme_addr  = vme_bbsy ? addr_l : '0;
   assign vme_dout  = vme_doe ? wdata_l : '0;

   always_comb begin
      accept = cmd_valid && cmd_ready;
      done   = 1'b0;
      err_n  = RSP_OK;
      nxt    = state;
      case (state)
         IDLE:  if (accept) nxt = REQ;
         REQ:   if (grant_s) nxt = SETUP;
         SETUP: if (scnt == S_LAST) nxt = DSTB;
         DSTB: begin
            done  = berr_s || dtack_s || tcnt == T_LAST;
            err_n = berr_s ? RSP_BERR : dtack_s ? RSP_OK : RSP_TMO;
            if (done) nxt = TERM;
         end
         // a timed-out slave may never negate its strobes, so do not wait on them
         TERM:  if (tmo_l || (!dtack_s && !berr_s))
                   nxt = (RELEASE_MODE == ROR && !sticky && !other_req) ? PARK : IDLE;
         PARK:  nxt = accept ? SETUP : other_req ? IDLE : PARK;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cmd_ready <= 1'b0;
         wr_l      <= 1'b0;
         addr_l    <= '0;
         wdata_l   <= '0;
         scnt      <= '0;
         tcnt      <= '0;
         tmo_l     <= 1'b0;
         sticky    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= RSP_OK;
         rsp_rdata <= '0;
      end else begin
         state     <= nxt;
         cmd_ready <= nxt == IDLE || nxt == PARK;
         if (accept) begin
            wr_l    <= cmd_write;
            addr_l  <= cmd_addr;
            wdata_l <= cmd_wdata;
         end
         scnt      <= state == SETUP ? scnt + 1'b1 : '0;
         tcnt      <= (state == DSTB && nxt == DSTB) ? tcnt + 1'b1 : '0;
         if (done) tmo_l <= err_n == RSP_TMO;
         sticky    <= vme_bbsy && (sticky || other_req);
         rsp_valid <= done;
         rsp_err   <= done ? err_n : RSP_OK;
         rsp_rdata <= (done && err_n == RSP_OK && !wr_l) ? vme_din : '0;
      end
   end
endmodule

// File: tb/tb_vme_master_cycle_ctrl.sv
// tb_vme_master_cycle_ctrl: scoreboard bench for RWD and ROR instances of the VME master
module tb_vme_master_cycle_ctrl;
   import vme_pkg::*;

   typedef struct {logic [1:0] err; logic [31:0] rdata;} exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int errs = 0, checks = 0;

   logic clk = 0, rst = 1;
   logic cmd_valid_a = 0, cmd_valid_b = 0, cmd_write = 0;
   logic [31:0] cmd_addr = 0, cmd_wdata = 0, vme_din = 0;
   logic bus_grant = 0, other_req = 0, vme_dtack = 0, vme_berr = 0;

   logic a_rdy, a_rv, a_breq, a_bbsy, a_as, a_ds, a_write, a_doe;
   logic [1:0] a_err;
   logic [31:0] a_rdata, a_addr, a_dout;
   logic b_rdy, b_rv, b_breq, b_bbsy, b_as, b_ds, b_write, b_doe;
   logic [1:0] b_err;
   logic [31:0] b_rdata, b_addr, b_dout;

   bit sel = 0;
   logic m_rdy, m_breq, m_bbsy, m_as, m_ds, m_doe;
   logic [31:0] m_addr;
   assign m_rdy  = sel ? b_rdy  : a_rdy;
   assign m_breq = sel ? b_breq : a_breq;
   assign m_bbsy = sel ? b_bbsy : a_bbsy;
   assign m_as   = sel ? b_as   : a_as;
   assign m_ds   = sel ? b_ds   : a_ds;
   assign m_doe  = sel ? b_doe  : a_doe;
   assign m_addr = sel ? b_addr : a_addr;

   always #5 clk = ~clk;

   vme_master_cycle_ctrl #(.RELEASE_MODE(RWD)) u_rwd (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(a_rdy), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(a_rv), .rsp_err(a_err),
      .rsp_rdata(a_rdata), .bus_req(a_breq), .bus_grant(bus_grant), .other_req(other_req),
      .vme_bbsy(a_bbsy), .vme_as(a_as), .vme_ds(a_ds), .vme_write(a_write), .vme_addr(a_addr),
      .vme_dout(a_dout), .vme_doe(a_doe), .vme_din(vme_din), .vme_dtack(vme_dtack), .vme_berr(vme_berr));

   vme_master_cycle_ctrl #(.RELEASE_MODE(ROR)) u_ror (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(b_rdy), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(b_rv), .rsp_err(b_err),
      .rsp_rdata(b_rdata), .bus_req(b_breq), .bus_grant(bus_grant), .other_req(other_req),
      .vme_bbsy(b_bbsy), .vme_as(b_as), .vme_ds(b_ds), .vme_write(b_write), .vme_addr(b_addr),
      .vme_dout(b_dout), .vme_doe(b_doe), .vme_din(vme_din), .vme_dtack(vme_dtack), .vme_berr(vme_berr));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   int b_breq_rises = 0, b_bbsy_falls = 0;
   logic b_breq_d = 0, b_bbsy_d = 0;
   always @(negedge clk) begin
      b_breq_rises <= b_breq_rises + int'(b_breq && !b_breq_d);
      b_bbsy_falls <= b_bbsy_falls + int'(!b_bbsy && b_bbsy_d);
      b_breq_d     <= b_breq;
      b_bbsy_d     <= b_bbsy;
   end

   always @(negedge clk) begin
      if (!rst && (a_rv || b_rv)) begin
         if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
         else begin
            mon_e = sb.pop_front();
            chk("rsp_err", 32'(a_rv ? a_err : b_err), 32'(mon_e.err));
            chk("rsp_rdata", a_rv ? a_rdata : b_rdata, mon_e.rdata);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] err, input logic [31:0] rd);
      cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      if (sel) cmd_valid_b = 1; else cmd_valid_a = 1;
      for (int i = 0; i < 20 && !m_rdy; i++) @(negedge clk);
      chk("cmd_ready", 32'(m_rdy), 32'd1);
      sb.push_back('{err, rd});
      @(negedge clk);
      cmd_valid_a = 0; cmd_valid_b = 0;
      chk("cmd_ready_drop", 32'(m_rdy), 32'd0);
   endtask

   task automatic get_bus(input int gdly);
      for (int i = 0; i < 20 && !m_breq; i++) @(negedge clk);
      chk("bus_req", 32'(m_breq), 32'd1);
      tick(gdly);
      bus_grant = 1;
      for (int i = 0; i < 20 && !m_bbsy; i++) @(negedge clk);
      chk("bbsy_up", 32'(m_bbsy), 32'd1);
      chk("bus_req_drop", 32'(m_breq), 32'd0);
      bus_grant = 0;
   endtask

   task automatic slave(input int dly, input logic ack, input logic be, input logic [31:0] din,
                        input logic orq, output int n, output logic doe_seen);
      n = 0; doe_seen = 0;
      for (int i = 0; i < 20 && !m_ds; i++) @(negedge clk);
      chk("ds_up", 32'(m_ds), 32'd1);
      while (m_ds && n < 300) begin
         doe_seen |= m_doe;
         other_req = orq && n == 1;
         if (n == dly) begin
            vme_dtack = ack; vme_berr = be; vme_din = din;
         end
         n++;
         @(negedge clk);
      end
      other_req = 0;
   endtask

   task automatic finish_term(input string tag);
      vme_dtack = 0; vme_berr = 0;
      for (int i = 0; i < 20 && m_bbsy; i++) @(negedge clk);
      chk(tag, 32'(m_bbsy), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errs, checks);
      $fatal(1);
   end

   initial begin
      int n;
      logic doe;
      int rises0, falls0;
      tick(3);
      chk("rst_cmd_ready", 32'(a_rdy), 32'd0);
      chk("rst_bbsy", 32'(a_bbsy), 32'd0);
      chk("rst_bus_req", 32'(a_breq), 32'd0);
      chk("rst_as_ds", 32'({a_as, a_ds}), 32'd0);
      chk("rst_rsp_valid", 32'(a_rv), 32'd0);
      chk("rst_addr", a_addr, 32'd0);
      chk("rst_ror_ready", 32'(b_rdy), 32'd0);
      rst = 0;

      do_cmd(1, 32'h1000_0040, 32'hDEAD_BEEF, RSP_OK, 32'd0);
      get_bus(3);
      chk("wr_addr", m_addr, 32'h1000_0040);
      chk("wr_write", 32'(a_write), 32'd1);
      chk("wr_doe", 32'(a_doe), 32'd1);
      chk("wr_dout", a_dout, 32'hDEAD_BEEF);
      chk("as_setup0", 32'(m_as), 32'd0);
      tick(1);
      chk("as_setup1", 32'(m_as), 32'd0);
      tick(1);
      chk("as_at2", 32'(m_as), 32'd1);
      chk("ds_at2", 32'(m_ds), 32'd1);
      slave(4, 1, 0, 32'hFFFF_FFFF, 0, n, doe);
      chk("wr_doe_dstb", 32'(doe), 32'd1);
      tick(2);
      chk("term_hold", 32'(m_bbsy), 32'd1);
      finish_term("rwd_release");

      do_cmd(0, 32'h2000_0008, 32'h5A5A_5A5A, RSP_OK, 32'h1234_5678);
      get_bus(1);
      chk("rd_doe_setup", 32'(m_doe), 32'd0);
      slave(2, 1, 0, 32'h1234_5678, 0, n, doe);
      chk("rd_doe_dstb", 32'(doe), 32'd0);
      finish_term("rd_release");

      do_cmd(0, 32'h3000_0000, 32'd0, RSP_BERR, 32'd0);
      get_bus(1);
      slave(3, 0, 1, 32'h1111_2222, 0, n, doe);
      finish_term("berr_release");
      do_cmd(0, 32'h3000_0004, 32'd0, RSP_BERR, 32'd0);
      get_bus(1);
      slave(3, 1, 1, 32'h3333_4444, 0, n, doe);
      finish_term("both_release");

      do_cmd(0, 32'h4000_0000, 32'd0, RSP_TMO, 32'd0);
      get_bus(1);
      slave(62, 1, 0, 32'h5555_6666, 0, n, doe);
      chk("tmo_ds_cycles", 32'(n), 32'd64);
      tick(1);
      chk("tmo_no_wait", 32'(m_bbsy), 32'd0);
      finish_term("tmo_release");

      sel = 1;
      rises0 = b_breq_rises;
      falls0 = b_bbsy_falls;
      do_cmd(1, 32'h5000_0010, 32'h0BAD_F00D, RSP_OK, 32'd0);
      get_bus(2);
      slave(3, 1, 0, 32'd0, 0, n, doe);
      vme_dtack = 0;
      tick(6);
      chk("ror_park_bbsy", 32'(m_bbsy), 32'd1);
      chk("ror_park_ready", 32'(m_rdy), 32'd1);
      do_cmd(0, 32'h5000_0014, 32'd0, RSP_OK, 32'hCAFE_F00D);
      chk("ror_no_req", 32'(m_breq), 32'd0);
      chk("ror_bbsy_held", 32'(m_bbsy), 32'd1);
      slave(3, 1, 0, 32'hCAFE_F00D, 1, n, doe);
      chk("ror_one_req", 32'(b_breq_rises - rises0), 32'd1);
      chk("ror_bbsy_cont", 32'(b_bbsy_falls - falls0), 32'd0);
      finish_term("ror_release");
      chk("sb_empty", 32'(sb.size()), 32'd0);

      sel = 0;
      do_cmd(1, 32'h6000_0000, 32'h7777_8888, RSP_OK, 32'd0);
      get_bus(1);
      for (int i = 0; i < 20 && !m_ds; i++) @(negedge clk);
      chk("rst_mid_ds", 32'(m_ds), 32'd1);
      tick(2);
      rst = 1;
      #1;
      chk("rst_mid_as_ds", 32'({a_as, a_ds}), 32'd0);
      chk("rst_mid_bbsy", 32'(a_bbsy), 32'd0);
      chk("rst_mid_bus_req", 32'(a_breq), 32'd0);
      chk("rst_mid_ready", 32'(a_rdy), 32'd0);
      sb.delete();
      tick(2);
      rst = 0;
      tick(10);
      chk("post_rst_idle", 32'(a_bbsy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
